// File: rtl/front_panel_ctrl_if.sv
// Front-panel controller signal bundle: switches, CPU taps,
// panel memory port and lamp drives.
interface front_panel_ctrl_if;

  logic        sw_run;
  logic        sw_stop;
  logic        sw_step;
  logic        sw_exam;
  logic        sw_exam_next;
  logic        sw_dep;
  logic        sw_dep_next;
  logic [15:0] sense_sw;

  logic        cpu_sync;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_ce;

  logic        bus_sel;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  logic [15:0] addr_leds;
  logic [7:0]  data_leds;
  logic        wait_led;

  // Controller side: owns the panel memory port and lamps.
  modport master (
    input  sw_run,
    input  sw_stop,
    input  sw_step,
    input  sw_exam,
    input  sw_exam_next,
    input  sw_dep,
    input  sw_dep_next,
    input  sense_sw,
    input  cpu_sync,
    input  cpu_addr,
    input  cpu_data,
    input  mem_rdata,
    output cpu_ce,
    output bus_sel,
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output addr_leds,
    output data_leds,
    output wait_led
  );

  // Environment side: switch decoder, CPU, RAM mux, renderer.
  modport slave (
    output sw_run,
    output sw_stop,
    output sw_step,
    output sw_exam,
    output sw_exam_next,
    output sw_dep,
    output sw_dep_next,
    output sense_sw,
    output cpu_sync,
    output cpu_addr,
    output cpu_data,
    output mem_rdata,
    input  cpu_ce,
    input  bus_sel,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  addr_leds,
    input  data_leds,
    input  wait_led
  );

endinterface

// File: rtl/front_panel_ctrl.sv
// Altair front-panel sequencer: run/stop/step of the 8080 core
// and examine/deposit of main memory while the CPU is halted.
module front_panel_ctrl #(
  parameter logic [15:0] RESET_ADDR    = 16'h0000,
  parameter bit          START_RUNNING = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  front_panel_ctrl_if.master fp
);

  typedef enum logic [2:0] {
    STOPPED,
    RUNNING,
    STOPPING,
    STEP,
    RD_ADDR,
    RD_DATA,
    WR
  } state_t;

  localparam state_t RST_STATE =
    START_RUNNING ? RUNNING : STOPPED;

  state_t      state_q, state_d;
  logic [15:0] panel_q, panel_d;
  logic        ce_q, ce_d;
  logic        bsel_q, bsel_d;
  logic        wait_q, wait_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] aled_q, aled_d;
  logic [7:0]  dled_q, dled_d;
  logic        arm_q, arm_d;

  logic [15:0] panel_inc;

  assign panel_inc = panel_q + 16'd1;

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_STATE;
      panel_q <= RESET_ADDR;
      ce_q    <= START_RUNNING;
      bsel_q  <= ~START_RUNNING;
      wait_q  <= ~START_RUNNING;
      wdata_q <= 8'h00;
      aled_q  <= RESET_ADDR;
      dled_q  <= 8'h00;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      panel_q <= panel_d;
      ce_q    <= ce_d;
      bsel_q  <= bsel_d;
      wait_q  <= wait_d;
      wdata_q <= wdata_d;
      aled_q  <= aled_d;
      dled_q  <= dled_d;
      arm_q   <= arm_d;
    end
  end

  // Command decode and sequencing; arm flags the first STEP
  // cycle so a sync already in flight does not end the step.
  always_comb begin
    state_d = state_q;
    panel_d = panel_q;
    ce_d    = ce_q;
    bsel_d  = bsel_q;
    wait_d  = wait_q;
    wdata_d = wdata_q;
    aled_d  = aled_q;
    dled_d  = dled_q;
    arm_d   = 1'b0;

    unique case (state_q)
      STOPPED: begin
        if (!fp.sw_stop) begin
          if (fp.sw_run) begin
            state_d = RUNNING;
            ce_d    = 1'b1;
            bsel_d  = 1'b0;
            wait_d  = 1'b0;
          end else if (fp.sw_step) begin
            state_d = STEP;
            ce_d    = 1'b1;
            bsel_d  = 1'b0;
            arm_d   = 1'b1;
          end else if (fp.sw_exam) begin
            state_d = RD_ADDR;
            panel_d = fp.sense_sw;
            aled_d  = fp.sense_sw;
          end else if (fp.sw_exam_next) begin
            state_d = RD_ADDR;
            panel_d = panel_inc;
            aled_d  = panel_inc;
          end else if (fp.sw_dep) begin
            state_d = WR;
            wdata_d = fp.sense_sw[7:0];
            aled_d  = panel_q;
          end else if (fp.sw_dep_next) begin
            state_d = WR;
            panel_d = panel_inc;
            aled_d  = panel_inc;
            wdata_d = fp.sense_sw[7:0];
          end
        end
      end

      RUNNING: begin
        aled_d = fp.cpu_addr;
        dled_d = fp.cpu_data;
        if (fp.sw_stop) begin
          state_d = STOPPING;
        end
      end

      STOPPING: begin
        aled_d = fp.cpu_addr;
        dled_d = fp.cpu_data;
        if (fp.cpu_sync) begin
          state_d = STOPPED;
          ce_d    = 1'b0;
          bsel_d  = 1'b1;
          wait_d  = 1'b1;
          panel_d = fp.cpu_addr;
          aled_d  = fp.cpu_addr;
          dled_d  = fp.cpu_data;
        end
      end

      STEP: begin
        if (fp.cpu_sync && !arm_q) begin
          state_d = STOPPED;
          ce_d    = 1'b0;
          bsel_d  = 1'b1;
          wait_d  = 1'b1;
          panel_d = fp.cpu_addr;
          aled_d  = fp.cpu_addr;
          dled_d  = fp.cpu_data;
        end
      end

      RD_ADDR: begin
        state_d = RD_DATA;
      end

      RD_DATA: begin
        state_d = STOPPED;
        dled_d  = fp.mem_rdata;
      end

      WR: begin
        state_d = RD_ADDR;
      end

      default: begin
        state_d = STOPPED;
      end
    endcase
  end

  assign fp.cpu_ce    = ce_q;
  assign fp.bus_sel   = bsel_q;
  assign fp.wait_led  = wait_q;
  assign fp.mem_addr  = panel_q;
  assign fp.mem_wdata = wdata_q;
  assign fp.mem_we    = (state_q == WR);
  assign fp.addr_leds = aled_q;
  assign fp.data_leds = dled_q;

endmodule

// File: tb/tb_front_panel_ctrl.sv
// Directed bench for front_panel_ctrl with a synchronous
// RAM model; inputs driven and outputs sampled on negedge.
module tb_front_panel_ctrl;

  localparam logic [15:0] RA = 16'hC000;

  localparam logic [6:0] C_STOP = 7'b0000001;
  localparam logic [6:0] C_RUN  = 7'b0000010;
  localparam logic [6:0] C_STEP = 7'b0000100;
  localparam logic [6:0] C_EXAM = 7'b0001000;
  localparam logic [6:0] C_EXNX = 7'b0010000;
  localparam logic [6:0] C_DEP  = 7'b0100000;
  localparam logic [6:0] C_DPNX = 7'b1000000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  front_panel_ctrl_if bus ();

  front_panel_ctrl #(
    .RESET_ADDR(RA),
    .START_RUNNING(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fp(bus)
  );

  logic [7:0]  mem [0:65535];
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;

  int we_cnt = 0;
  int we_bad = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_we) we_cnt <= we_cnt + 1;
    if (bus.mem_we && !bus.bus_sel) we_bad <= we_bad + 1;
  end

  task automatic pulse(input logic [6:0] c);
    {bus.sw_dep_next, bus.sw_dep, bus.sw_exam_next,
     bus.sw_exam, bus.sw_step, bus.sw_run, bus.sw_stop} = c;
    @(negedge clk);
    {bus.sw_dep_next, bus.sw_dep, bus.sw_exam_next,
     bus.sw_exam, bus.sw_step, bus.sw_run, bus.sw_stop} = '0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    bd_we = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus.addr_leds !== RA) begin
      bad++;
      $display("FAIL rst_aled got=%h exp=%h", bus.addr_leds, RA);
    end
    total++;
    if (bus.mem_addr !== RA) begin
      bad++;
      $display("FAIL rst_maddr got=%h exp=%h", bus.mem_addr, RA);
    end
    total++;
    if ({bus.cpu_ce, bus.bus_sel, bus.wait_led, bus.mem_we}
        !== 4'b0110) begin
      bad++;
      $display("FAIL rst_ctl got=%b%b%b%b exp=0110", bus.cpu_ce,
               bus.bus_sel, bus.wait_led, bus.mem_we);
    end
    total++;
    if ({bus.data_leds, bus.mem_wdata} !== 16'h0000) begin
      bad++;
      $display("FAIL rst_data got=%h/%h exp=00/00",
               bus.data_leds, bus.mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exam;
    int w0;
    poke(16'h1234, 8'hA5);
    bus.sense_sw = 16'h1234;
    w0 = we_cnt;
    pulse(C_EXAM);
    total++;
    if (bus.addr_leds !== 16'h1234) begin
      bad++;
      $display("FAIL exam_aled got=%h exp=1234", bus.addr_leds);
    end
    total++;
    if (bus.mem_addr !== 16'h1234) begin
      bad++;
      $display("FAIL exam_maddr got=%h exp=1234", bus.mem_addr);
    end
    @(negedge clk);
    total++;
    if (bus.data_leds !== 8'h00) begin
      bad++;
      $display("FAIL exam_early got=%h exp=00", bus.data_leds);
    end
    @(negedge clk);
    total++;
    if (bus.data_leds !== 8'hA5) begin
      bad++;
      $display("FAIL exam_dled got=%h exp=a5", bus.data_leds);
    end
    total++;
    if (we_cnt - w0 != 0) begin
      bad++;
      $display("FAIL exam_we got=%0d exp=0", we_cnt - w0);
    end
    total++;
    if ({bus.bus_sel, bus.wait_led, bus.cpu_ce} !== 3'b110) begin
      bad++;
      $display("FAIL exam_stopped got=%b%b%b exp=110",
               bus.bus_sel, bus.wait_led, bus.cpu_ce);
    end
  endtask

  task automatic test_dep_next;
    int w0;
    bus.sense_sw = 16'hFFFF;
    pulse(C_EXAM);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.addr_leds !== 16'hFFFF) begin
      bad++;
      $display("FAIL dpnx_pre got=%h exp=ffff", bus.addr_leds);
    end
    bus.sense_sw = 16'hAB3C;
    w0 = we_cnt;
    pulse(C_DPNX);
    total++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata}
        !== {1'b1, 16'h0000, 8'h3C}) begin
      bad++;
      $display("FAIL dpnx_wr got=%b/%h/%h exp=1/0000/3c",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    total++;
    if (bus.addr_leds !== 16'h0000) begin
      bad++;
      $display("FAIL dpnx_aled got=%h exp=0000", bus.addr_leds);
    end
    @(negedge clk);
    total++;
    if (bus.mem_we !== 1'b0) begin
      bad++;
      $display("FAIL dpnx_we_drop got=%b exp=0", bus.mem_we);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.data_leds !== 8'h3C) begin
      bad++;
      $display("FAIL dpnx_dled got=%h exp=3c", bus.data_leds);
    end
    total++;
    if (we_cnt - w0 != 1) begin
      bad++;
      $display("FAIL dpnx_we_cnt got=%0d exp=1", we_cnt - w0);
    end
  endtask

  task automatic test_dep;
    bus.sense_sw = 16'h5581;
    pulse(C_DEP);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.addr_leds, bus.data_leds} !== {16'h0000, 8'h81}) begin
      bad++;
      $display("FAIL dep got=%h/%h exp=0000/81",
               bus.addr_leds, bus.data_leds);
    end
  endtask

  task automatic test_run_stop;
    int n;
    bus.cpu_addr = 16'h0200;
    bus.cpu_data = 8'h11;
    pulse(C_RUN);
    total++;
    if ({bus.cpu_ce, bus.bus_sel, bus.wait_led} !== 3'b100) begin
      bad++;
      $display("FAIL run_ctl got=%b%b%b exp=100",
               bus.cpu_ce, bus.bus_sel, bus.wait_led);
    end
    @(negedge clk);
    total++;
    if ({bus.addr_leds, bus.data_leds} !== {16'h0200, 8'h11}) begin
      bad++;
      $display("FAIL run_mirror got=%h/%h exp=0200/11",
               bus.addr_leds, bus.data_leds);
    end
    pulse(C_STOP);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      bus.cpu_addr = 16'h0300 + 16'(i);
      if (!bus.cpu_ce) n++;
      @(negedge clk);
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL stopping_ce got=%0d low exp=0", n);
    end
    bus.cpu_sync = 1'b1;
    bus.cpu_addr = 16'h0105;
    bus.cpu_data = 8'h3E;
    @(negedge clk);
    bus.cpu_sync = 1'b0;
    bus.cpu_addr = 16'h0106;
    total++;
    if ({bus.cpu_ce, bus.bus_sel, bus.wait_led} !== 3'b011) begin
      bad++;
      $display("FAIL stop_ctl got=%b%b%b exp=011",
               bus.cpu_ce, bus.bus_sel, bus.wait_led);
    end
    total++;
    if ({bus.addr_leds, bus.data_leds, bus.mem_addr}
        !== {16'h0105, 8'h3E, 16'h0105}) begin
      bad++;
      $display("FAIL stop_cap got=%h/%h/%h exp=0105/3e/0105",
               bus.addr_leds, bus.data_leds, bus.mem_addr);
    end
    @(negedge clk);
    total++;
    if (bus.addr_leds !== 16'h0105) begin
      bad++;
      $display("FAIL stop_hold got=%h exp=0105", bus.addr_leds);
    end
  endtask

  task automatic test_step;
    int n;
    int w;
    bus.cpu_addr = 16'h0042;
    bus.cpu_data = 8'h77;
    pulse(C_STEP);
    n = 0;
    w = 0;
    for (int i = 0; i < 10; i++) begin
      bus.cpu_sync = (i == 0) || (i == 4);
      if (bus.cpu_ce) n++;
      if (!bus.wait_led) w++;
      @(negedge clk);
    end
    bus.cpu_sync = 1'b0;
    total++;
    if (n != 5) begin
      bad++;
      $display("FAIL step_ce_cycles got=%0d exp=5", n);
    end
    total++;
    if (w != 0) begin
      bad++;
      $display("FAIL step_wait got=%0d low exp=0", w);
    end
    total++;
    if ({bus.bus_sel, bus.addr_leds, bus.mem_addr}
        !== {1'b1, 16'h0042, 16'h0042}) begin
      bad++;
      $display("FAIL step_end got=%b/%h/%h exp=1/0042/0042",
               bus.bus_sel, bus.addr_leds, bus.mem_addr);
    end
  endtask

  task automatic test_priority;
    int w0;
    bus.sense_sw = 16'h1234;
    w0 = we_cnt;
    pulse(C_EXAM | C_DEP);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.addr_leds, bus.data_leds} !== {16'h1234, 8'hA5}) begin
      bad++;
      $display("FAIL pri_exam got=%h/%h exp=1234/a5",
               bus.addr_leds, bus.data_leds);
    end
    total++;
    if (we_cnt - w0 != 0) begin
      bad++;
      $display("FAIL pri_nowrite got=%0d exp=0", we_cnt - w0);
    end
    pulse(C_STOP | C_RUN);
    @(negedge clk);
    total++;
    if ({bus.cpu_ce, bus.bus_sel} !== 2'b01) begin
      bad++;
      $display("FAIL pri_stoprun got=%b%b exp=01",
               bus.cpu_ce, bus.bus_sel);
    end
    bus.cpu_addr = 16'h0400;
    pulse(C_RUN);
    bus.sense_sw = 16'h5555;
    pulse(C_EXAM);
    total++;
    if ({bus.cpu_ce, bus.bus_sel} !== 2'b10) begin
      bad++;
      $display("FAIL pri_run_exam got=%b%b exp=10",
               bus.cpu_ce, bus.bus_sel);
    end
    pulse(C_STOP);
    bus.cpu_sync = 1'b1;
    @(negedge clk);
    bus.cpu_sync = 1'b0;
    total++;
    if ({bus.bus_sel, bus.mem_addr} !== {1'b1, 16'h0400}) begin
      bad++;
      $display("FAIL pri_exam_ignored got=%b/%h exp=1/0400",
               bus.bus_sel, bus.mem_addr);
    end
  endtask

  task automatic test_reset_mid_wr;
    int w0;
    bus.sense_sw = 16'h0077;
    w0 = we_cnt;
    pulse(C_EXNX | C_DPNX);
    @(negedge clk);
    @(negedge clk);
    pulse(C_DEP);
    total++;
    if (bus.mem_we !== 1'b1) begin
      bad++;
      $display("FAIL rwr_in_wr got=%b exp=1", bus.mem_we);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.mem_we, bus.cpu_ce, bus.bus_sel, bus.wait_led}
        !== 4'b0011) begin
      bad++;
      $display("FAIL rwr_ctl got=%b%b%b%b exp=0011", bus.mem_we,
               bus.cpu_ce, bus.bus_sel, bus.wait_led);
    end
    total++;
    if ({bus.addr_leds, bus.mem_addr, bus.data_leds, bus.mem_wdata}
        !== {RA, RA, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL rwr_vals got=%h/%h/%h/%h exp=%h/%h/00/00",
               bus.addr_leds, bus.mem_addr, bus.data_leds,
               bus.mem_wdata, RA, RA);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (we_cnt - w0 != 1) begin
      bad++;
      $display("FAIL rwr_we_cnt got=%0d exp=1", we_cnt - w0);
    end
    total++;
    if (bus.data_leds !== 8'h00) begin
      bad++;
      $display("FAIL rwr_no_refresh got=%h exp=00", bus.data_leds);
    end
  endtask

  initial begin
    reset = 1'b1;
    bd_we = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    bus.sense_sw = '0;
    bus.cpu_sync = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_data = '0;
    {bus.sw_dep_next, bus.sw_dep, bus.sw_exam_next,
     bus.sw_exam, bus.sw_step, bus.sw_run, bus.sw_stop} = '0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_exam();
    test_dep_next();
    test_dep();
    test_run_stop();
    test_step();
    test_priority();
    test_reset_mid_wr();
    total++;
    if (we_bad != 0) begin
      bad++;
      $display("FAIL we_while_cpu got=%0d exp=0", we_bad);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
